// File: rtl/scaler_linebuf_ctrl.sv
// Line-buffer controller: fills a single-port RAM with one line, then replays it i_repeat times.
// Optional SCALER_LB_DONE_PULSE_EN adds o_line_done, a one-cycle pulse after the last replay read.
//
// state    | meaning
// ST_FILL  | accepting input pixels, writing RAM at wr_ptr
// ST_DRAIN | reading RAM at rd_ptr into the output register, replaying rep_cnt more times
module scaler_linebuf_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 30,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [3:0]            i_repeat,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic [DATA_WIDTH-1:0] o_pix_data,
  output logic                  o_busy,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
`ifdef SCALER_LB_DONE_PULSE_EN
  output logic                  o_line_done,
`endif
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(LINE_WIDTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]            rep_cnt_q, rep_cnt_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  final_rd;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rep_cnt_d   = rep_cnt_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    o_in_ready  = 1'b0;
    wr_fire     = 1'b0;
    rd_fire     = 1'b0;
    final_rd    = 1'b0;
    o_ram_cs    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_din   = '0;

    unique case (state_q)
      ST_FILL: begin
        o_in_ready = !i_rst;
        wr_fire    = o_in_ready && i_in_valid;
        // A replayed pixel may still be waiting here from the previous line.
        if (i_pix_ready) begin
          pix_valid_d = 1'b0;
        end
        if (wr_fire) begin
          o_ram_cs   = 1'b1;
          o_ram_we   = 1'b1;
          o_ram_addr = wr_ptr_q;
          o_ram_din  = i_in_data;
          if (wr_ptr_q == '0) begin
            rep_cnt_d = (i_repeat == 4'd0) ? 4'd0 : i_repeat - 4'd1;
          end
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end

      ST_DRAIN: begin
        rd_fire = !i_rst && (!pix_valid_q || i_pix_ready);
        if (rd_fire) begin
          o_ram_cs    = 1'b1;
          o_ram_addr  = rd_ptr_q;
          pix_data_d  = i_ram_dout;
          pix_valid_d = 1'b1;
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
            if (rep_cnt_q == 4'd0) begin
              final_rd = 1'b1;
              state_d  = ST_FILL;
            end else begin
              rep_cnt_d = rep_cnt_q - 4'd1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rep_cnt_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rep_cnt_q   <= rep_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign o_pix_valid = pix_valid_q;
  assign o_pix_data  = pix_data_q;
  assign o_busy      = (state_q == ST_DRAIN) || pix_valid_q;

`ifdef SCALER_LB_DONE_PULSE_EN
  logic line_done_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= final_rd;
    end
  end

  assign o_line_done = line_done_q;
`else
  logic unused_final_rd;
  assign unused_final_rd = final_rd;
`endif

endmodule
